// File: rtl/me_result_decode_if.sv
// Result bus between a motion-estimation core and its decoder: request side
// (ack/min_cnt/min_sad/clr) plus the decoded vector and running statistics.
interface me_result_decode_if #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8
);
  localparam int RANGE     = SW_LENGTH - TB_LENGTH + 1;
  localparam int CNT_WIDTH = $clog2(RANGE * RANGE);
  localparam int SAD_WIDTH = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH;
  localparam int MV_WIDTH  = $clog2(RANGE) + 1;

  logic                 ack;
  logic [CNT_WIDTH-1:0] min_cnt;
  logic [SAD_WIDTH-1:0] min_sad;
  logic                 clr;
  logic [MV_WIDTH-1:0]  mv_x;
  logic [MV_WIDTH-1:0]  mv_y;
  logic [SAD_WIDTH-1:0] sad;
  logic                 valid;
  logic                 busy;
  logic                 err;
  logic [7:0]           run_cnt;
  logic [SAD_WIDTH-1:0] best_sad;
  logic                 overrun;

  modport master (
    output ack, min_cnt, min_sad, clr,
    input  mv_x, mv_y, sad, valid, busy, err, run_cnt, best_sad, overrun
  );

  modport slave (
    input  ack, min_cnt, min_sad, clr,
    output mv_x, mv_y, sad, valid, busy, err, run_cnt, best_sad, overrun
  );
endinterface

// File: rtl/me_result_decode.sv
// Turns the row-major best-candidate index of a full-search ME core into a
// signed motion vector using repeated subtraction, and tracks result statistics.
module me_result_decode #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  me_result_decode_if.slave   bus
);
  localparam int RANGE     = SW_LENGTH - TB_LENGTH + 1;
  localparam int CNT_WIDTH = $clog2(RANGE * RANGE);
  localparam int SAD_WIDTH = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH;
  localparam int MV_WIDTH  = $clog2(RANGE) + 1;
  localparam int OFS       = (RANGE - 1) / 2;

  // One extra bit so RANGE^2 stays representable when it is a power of two.
  localparam logic [CNT_WIDTH:0]   RANGE_SQ_EXT = (CNT_WIDTH + 1)'(RANGE * RANGE);
  localparam logic [CNT_WIDTH-1:0] RANGE_C      = CNT_WIDTH'(RANGE);
  localparam logic [MV_WIDTH-1:0]  OFS_C        = MV_WIDTH'(OFS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 ack_d_reg;
  logic [CNT_WIDTH-1:0] rem_reg, rem_next;
  logic [MV_WIDTH-1:0]  quo_reg, quo_next;
  logic [SAD_WIDTH-1:0] sad_r_reg, sad_r_next;
  logic                 oor_reg, oor_next;
  logic [MV_WIDTH-1:0]  mv_x_reg, mv_x_next;
  logic [MV_WIDTH-1:0]  mv_y_reg, mv_y_next;
  logic [SAD_WIDTH-1:0] sad_reg, sad_next;
  logic                 err_reg, err_next;
  logic                 valid_reg, valid_next;
  logic [7:0]           run_cnt_reg, run_cnt_next;
  logic [SAD_WIDTH-1:0] best_sad_reg, best_sad_next;
  logic                 overrun_reg, overrun_next;
  logic                 ack_edge;

  assign ack_edge = bus.ack & ~ack_d_reg;

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    quo_next      = quo_reg;
    sad_r_next    = sad_r_reg;
    oor_next      = oor_reg;
    mv_x_next     = mv_x_reg;
    mv_y_next     = mv_y_reg;
    sad_next      = sad_reg;
    err_next      = err_reg;
    valid_next    = 1'b0;
    run_cnt_next  = run_cnt_reg;
    best_sad_next = best_sad_reg;
    overrun_next  = overrun_reg;

    case (state_reg)
      IDLE: begin
        if (ack_edge) begin
          rem_next   = bus.min_cnt;
          sad_r_next = bus.min_sad;
          quo_next   = '0;
          oor_next   = ({1'b0, bus.min_cnt} >= RANGE_SQ_EXT);
          state_next = DIV;
        end
      end
      DIV: begin
        // An out-of-range index bypasses the subtraction loop entirely.
        if (!oor_reg && (rem_reg >= RANGE_C)) begin
          rem_next = rem_reg - RANGE_C;
          quo_next = quo_reg + MV_WIDTH'(1);
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid_next = 1'b1;
        sad_next   = sad_r_reg;
        err_next   = oor_reg;
        if (oor_reg) begin
          mv_x_next = '0;
          mv_y_next = '0;
        end else begin
          mv_x_next = MV_WIDTH'(rem_reg) - OFS_C;
          mv_y_next = quo_reg - OFS_C;
          if (run_cnt_reg != 8'hFF) begin
            run_cnt_next = run_cnt_reg + 8'd1;
          end
          if (sad_r_reg < best_sad_reg) begin
            best_sad_next = sad_r_reg;
          end
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (ack_edge && (state_reg != IDLE)) begin
      overrun_next = 1'b1;
    end

    // Clear only touches the statistics; an in-flight decode still completes.
    if (bus.clr) begin
      run_cnt_next  = '0;
      best_sad_next = '1;
      overrun_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ack_d_reg    <= 1'b0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      sad_r_reg    <= '0;
      oor_reg      <= 1'b0;
      mv_x_reg     <= '0;
      mv_y_reg     <= '0;
      sad_reg      <= '0;
      err_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      run_cnt_reg  <= '0;
      best_sad_reg <= '1;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ack_d_reg    <= bus.ack;
      rem_reg      <= rem_next;
      quo_reg      <= quo_next;
      sad_r_reg    <= sad_r_next;
      oor_reg      <= oor_next;
      mv_x_reg     <= mv_x_next;
      mv_y_reg     <= mv_y_next;
      sad_reg      <= sad_next;
      err_reg      <= err_next;
      valid_reg    <= valid_next;
      run_cnt_reg  <= run_cnt_next;
      best_sad_reg <= best_sad_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign bus.mv_x     = mv_x_reg;
  assign bus.mv_y     = mv_y_reg;
  assign bus.sad      = sad_reg;
  assign bus.valid    = valid_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.err      = err_reg;
  assign bus.run_cnt  = run_cnt_reg;
  assign bus.best_sad = best_sad_reg;
  assign bus.overrun  = overrun_reg;
endmodule

// File: tb/tb_me_result_decode.sv
// Directed bench for me_result_decode: a reference model pushes expected
// results into a queue at stimulus time; they are popped when valid fires.
module tb_me_result_decode;
  localparam int TB_LENGTH    = 16;
  localparam int SW_LENGTH    = 64;
  localparam int PE_OUT_WIDTH = 8;
  localparam int RANGE        = SW_LENGTH - TB_LENGTH + 1;
  localparam int OFS          = (RANGE - 1) / 2;
  localparam int CNT_WIDTH    = $clog2(RANGE * RANGE);
  localparam int SAD_WIDTH    = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH;
  localparam int SAD_ONES     = (1 << SAD_WIDTH) - 1;

  typedef struct {
    int mv_x;
    int mv_y;
    int sad;
    int err;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  me_result_decode_if #(
    .TB_LENGTH(TB_LENGTH), .SW_LENGTH(SW_LENGTH), .PE_OUT_WIDTH(PE_OUT_WIDTH)
  ) bus ();

  me_result_decode #(
    .TB_LENGTH(TB_LENGTH), .SW_LENGTH(SW_LENGTH), .PE_OUT_WIDTH(PE_OUT_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   n_cmp = 0;
  int   n_fail = 0;
  int   valid_cnt = 0;
  int   exp_run = 0;
  int   exp_best = SAD_ONES;
  int   exp_ovr = 0;
  exp_t sb[$];

  always @(negedge clk) begin
    if (bus.valid === 1'b1) valid_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"},    bus.valid, 0);
    check({tag, "_busy"},     bus.busy, 0);
    check({tag, "_mv_x"},     $signed(bus.mv_x), 0);
    check({tag, "_mv_y"},     $signed(bus.mv_y), 0);
    check({tag, "_sad"},      bus.sad, 0);
    check({tag, "_err"},      bus.err, 0);
    check({tag, "_run_cnt"},  bus.run_cnt, 0);
    check({tag, "_best_sad"}, bus.best_sad, SAD_ONES);
    check({tag, "_overrun"},  bus.overrun, 0);
    exp_run  = 0;
    exp_best = SAD_ONES;
    exp_ovr  = 0;
  endtask

  task automatic push_exp(input int cnt, input int sadv, input int inj_at, input int clr_at);
    exp_t e;
    if (cnt >= RANGE * RANGE) begin
      e.mv_x = 0;
      e.mv_y = 0;
      e.err  = 1;
      e.lat  = 2;
    end else begin
      e.mv_x = (cnt % RANGE) - OFS;
      e.mv_y = (cnt / RANGE) - OFS;
      e.err  = 0;
      e.lat  = (cnt / RANGE) + 2;
      if (exp_run < 255) exp_run++;
      if (sadv < exp_best) exp_best = sadv;
    end
    e.sad = sadv;
    if (inj_at >= 0) exp_ovr = 1;
    if (clr_at >= 0) begin
      exp_run  = 0;
      exp_best = SAD_ONES;
      exp_ovr  = 0;
    end
    sb.push_back(e);
  endtask

  // Called just after the capturing edge; counts edges until valid appears.
  task automatic wait_result(input int inj_at, input int clr_at, input bit hold);
    int   edges = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (edges < 60) begin
      bus.clr = (edges == clr_at);
      if (edges == inj_at) begin
        bus.ack     = 1'b1;
        bus.min_cnt = '0;
      end else if (!hold) begin
        bus.ack = 1'b0;
      end
      if (bus.valid === 1'b1) break;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      edges++;
    end
    bus.clr = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      e = '{0, 0, 0, 0, 0};
    end else begin
      e = sb.pop_front();
    end
    check("latency", edges, e.lat);
    check("busy_in_flight", busy_ok, 1);
    check("mv_x", $signed(bus.mv_x), e.mv_x);
    check("mv_y", $signed(bus.mv_y), e.mv_y);
    check("sad", bus.sad, e.sad);
    check("err", bus.err, e.err);
    $display("decode: lat=%0d mv=(%0d,%0d) sad=%0d err=%0d", edges,
             $signed(bus.mv_x), $signed(bus.mv_y), bus.sad, bus.err);
    tick();
    check("valid_one_cycle", bus.valid, 0);
    check("busy_after", bus.busy, 0);
    check("run_cnt", bus.run_cnt, exp_run);
    check("best_sad", bus.best_sad, exp_best);
    check("overrun", bus.overrun, exp_ovr);
  endtask

  task automatic run_decode(input int cnt, input int sadv, input int inj_at,
                            input int clr_at, input bit hold);
    int v0;
    v0 = valid_cnt;
    $display("start: min_cnt=%0d min_sad=%0d", cnt, sadv);
    push_exp(cnt, sadv, inj_at, clr_at);
    bus.min_cnt = CNT_WIDTH'(cnt);
    bus.min_sad = SAD_WIDTH'(sadv);
    bus.ack     = 1'b1;
    tick();
    wait_result(inj_at, clr_at, hold);
    repeat (3) tick();
    check("valid_count", valid_cnt - v0, 1);
    check("hold_mv_x", $signed(bus.mv_x), (cnt >= RANGE * RANGE) ? 0 : (cnt % RANGE) - OFS);
    bus.ack = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr  = 1'b0;
    exp_run  = 0;
    exp_best = SAD_ONES;
    exp_ovr  = 0;
    check("clr_run_cnt", bus.run_cnt, 0);
    check("clr_best_sad", bus.best_sad, SAD_ONES);
    check("clr_overrun", bus.overrun, 0);
    $display("clr applied");
  endtask

  initial begin
    int v0;
    rst_n       = 1'b0;
    bus.ack     = 1'b0;
    bus.clr     = 1'b0;
    bus.min_cnt = '0;
    bus.min_sad = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    run_decode(1200, 300, -1, -1, 1'b0);
    run_decode(0, 120, -1, -1, 1'b0);
    run_decode(2400, 500, -1, -1, 1'b0);
    run_decode(2401, 50, -1, -1, 1'b0);
    run_decode(4095, 40, -1, -1, 1'b0);
    pulse_clr();

    for (int i = 0; i < 3; i++) begin
      run_decode(int'($urandom_range(0, RANGE * RANGE - 1)),
                 int'($urandom_range(0, SAD_ONES - 1)), -1, -1, 1'b0);
    end

    run_decode(100, 55, -1, -1, 1'b1);
    run_decode(2400, 900, 4, -1, 1'b0);
    pulse_clr();
    run_decode(48, 10, -1, 1, 1'b0);

    v0 = valid_cnt;
    bus.min_cnt = CNT_WIDTH'(2400);
    bus.min_sad = SAD_WIDTH'(7);
    bus.ack     = 1'b1;
    tick();
    bus.ack = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check_reset_vals("mid_div_reset");
    rst_n = 1'b1;
    repeat (60) tick();
    check("no_valid_after_reset", valid_cnt - v0, 0);
    $display("mid-decode reset done");

    rst_n       = 1'b0;
    bus.ack     = 1'b1;
    bus.min_cnt = CNT_WIDTH'(49);
    bus.min_sad = SAD_WIDTH'(77);
    tick();
    check_reset_vals("reset_ack_high");
    v0 = valid_cnt;
    push_exp(49, 77, -1, -1);
    rst_n = 1'b1;
    tick();
    wait_result(-1, -1, 1'b0);
    repeat (3) tick();
    check("ack_after_reset_count", valid_cnt - v0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
